// File: rtl/digital_signal_pkg.sv
// Types and constants shared by the signal generate and signal measure blocks.
package digital_signal_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } gen_state_t;

endpackage

// File: rtl/digital_signal_generate.sv
// Programmable pulse/PWM generator: emits bursts (or a continuous train) of
// periods with programmed high and low times, under a level start/done handshake.
module digital_signal_generate
  import digital_signal_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gen_start,
  input  logic [CNT_W-1:0] high_time,
  input  logic [CNT_W-1:0] low_time,
  input  logic [CNT_W-1:0] pulse_count,
  output logic             gen_pin,
  output logic             gen_busy,
  output logic             gen_done,
  output logic [CNT_W-1:0] period_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  gen_state_t       state;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] hi_s, lo_s, cnt_s;
  logic [CNT_W-1:0] hi_eff, lo_eff, pc_next;
  logic             last_burst;

  // A zero-length level is stretched to one cycle so the pin always toggles.
  assign hi_eff     = (hi_s == '0) ? ONE : hi_s;
  assign lo_eff     = (lo_s == '0) ? ONE : lo_s;
  assign pc_next    = period_cnt + ONE;
  assign last_burst = (cnt_s != '0) && (pc_next == cnt_s);
  assign gen_busy   = (state == HIGH) || (state == LOW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      hi_s       <= '0;
      lo_s       <= '0;
      cnt_s      <= '0;
      period_cnt <= '0;
      gen_pin    <= 1'b0;
      gen_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gen_pin <= 1'b0;
          if (gen_start) begin
            state      <= HIGH;
            gen_pin    <= 1'b1;
            phase      <= ONE;
            period_cnt <= '0;
            gen_done   <= 1'b0;
            hi_s       <= high_time;
            lo_s       <= low_time;
            cnt_s      <= pulse_count;
          end
        end
        HIGH: begin
          if (phase == hi_eff) begin
            state   <= LOW;
            gen_pin <= 1'b0;
            phase   <= ONE;
          end else begin
            phase <= phase + ONE;
          end
        end
        LOW: begin
          if (phase == lo_eff) begin
            period_cnt <= pc_next;
            // Start is only checked at a period boundary, so an abort never truncates a pulse.
            if (!gen_start) begin
              state <= IDLE;
            end else if (last_burst) begin
              state    <= DONE;
              gen_done <= 1'b1;
            end else begin
              state   <= HIGH;
              gen_pin <= 1'b1;
              phase   <= ONE;
              hi_s    <= high_time;
              lo_s    <= low_time;
            end
          end else begin
            phase <= phase + ONE;
          end
        end
        DONE: begin
          gen_pin <= 1'b0;
          if (!gen_start) begin
            state    <= IDLE;
            gen_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digital_signal_generate.sv
// Scoreboard bench for digital_signal_generate: directed bursts push per-cycle
// expected outputs; a monitor pops and compares one entry after every clock edge.
module tb_digital_signal_generate;

  localparam int CNT_W = 16;

  typedef struct {
    logic             pin;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             gen_start;
  logic [CNT_W-1:0] high_time, low_time, pulse_count;
  logic             gen_pin, gen_busy, gen_done;
  logic [CNT_W-1:0] period_cnt;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Bench-side pulse-width measurement standing in for the measurement block.
  logic             meas_en = 1'b0;
  logic             prev_pin = 1'b0;
  int               run = 0;
  int               meas_hi = 0, meas_lo = 0;
  logic             hi_seen = 1'b0, lo_seen = 1'b0;

  digital_signal_generate #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .gen_start  (gen_start),
    .high_time  (high_time),
    .low_time   (low_time),
    .pulse_count(pulse_count),
    .gen_pin    (gen_pin),
    .gen_busy   (gen_busy),
    .gen_done   (gen_done),
    .period_cnt (period_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: one expected sample per clock edge while the queue has entries.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (gen_pin !== e.pin || gen_busy !== e.busy || gen_done !== e.done || period_cnt !== e.pc) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got pin=%b busy=%b done=%b pc=%0d, expected pin=%b busy=%b done=%b pc=%0d",
                 $time, gen_pin, gen_busy, gen_done, period_cnt, e.pin, e.busy, e.done, e.pc);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (meas_en) begin
      run      <= (gen_pin == prev_pin) ? run + 1 : 1;
      prev_pin <= gen_pin;
      if (gen_pin != prev_pin) begin
        if (prev_pin) begin
          meas_hi <= run;
          hi_seen <= 1'b1;
        end else if (hi_seen) begin
          meas_lo <= run;
          lo_seen <= 1'b1;
        end
      end
    end
  end

  task automatic cyc(input logic pin, input logic busy, input logic done, input int pc);
    exp_t x;
    x.pin = pin; x.busy = busy; x.done = done; x.pc = CNT_W'(pc);
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic seg(input logic lvl, input int len, input int pc);
    for (int i = 0; i < len; i++) cyc(lvl, 1'b1, 1'b0, pc);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic setup(input int hi, input int lo, input int cnt);
    high_time   = CNT_W'(hi);
    low_time    = CNT_W'(lo);
    pulse_count = CNT_W'(cnt);
    gen_start   = 1'b1;
  endtask

  initial begin
    rst = 1'b1; gen_start = 1'b0;
    high_time = '0; low_time = '0; pulse_count = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {gen_pin, gen_busy, gen_done, period_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic burst: 5 high / 3 low, two periods.
    setup(5, 3, 2);
    seg(1, 5, 0); seg(0, 3, 0); seg(1, 5, 1); seg(0, 3, 1);
    cyc(0, 0, 1, 2); cyc(0, 0, 1, 2);
    gen_start = 1'b0;
    cyc(0, 0, 0, 2); cyc(0, 0, 0, 2);

    // Zero times clamp to one cycle each.
    setup(0, 0, 3);
    seg(1, 1, 0); seg(0, 1, 0); seg(1, 1, 1); seg(0, 1, 1); seg(1, 1, 2); seg(0, 1, 2);
    cyc(0, 0, 1, 3);
    gen_start = 1'b0;
    cyc(0, 0, 0, 3);

    // Continuous mode, abort in the middle of the third high phase.
    setup(4, 4, 0);
    seg(1, 4, 0); seg(0, 4, 0); seg(1, 4, 1); seg(0, 4, 1); seg(1, 2, 2);
    gen_start = 1'b0;
    seg(1, 2, 2); seg(0, 4, 2);
    cyc(0, 0, 0, 3); cyc(0, 0, 0, 3);

    // Mid-run update: new high time applies from the second period; count change ignored.
    setup(2, 2, 4);
    seg(1, 1, 0);
    high_time = 16'd6; pulse_count = 16'd1;
    seg(1, 1, 0); seg(0, 2, 0);
    seg(1, 6, 1); seg(0, 2, 1); seg(1, 6, 2); seg(0, 2, 2); seg(1, 6, 3); seg(0, 2, 3);
    cyc(0, 0, 1, 4);
    gen_start = 1'b0;
    cyc(0, 0, 0, 4);

    // Async reset in the low phase, then a fresh burst on release.
    setup(10, 10, 0);
    seg(1, 10, 0); seg(0, 4, 0);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {gen_pin, gen_busy, gen_done, period_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    seg(1, 10, 0); seg(0, 10, 0); seg(1, 3, 1);
    gen_start = 1'b0;
    seg(1, 7, 1); seg(0, 10, 1);
    cyc(0, 0, 0, 2);

    // Loopback: measured widths of a 100/50 continuous train.
    meas_en = 1'b1;
    @(negedge clk);
    setup(100, 50, 0);
    seg(1, 100, 0); seg(0, 50, 0); seg(1, 100, 1);
    gen_start = 1'b0;
    seg(0, 50, 1);
    cyc(0, 0, 0, 2); cyc(0, 0, 0, 2);
    check("meas_high_in_range", int'(meas_hi >= 99 && meas_hi <= 101), 1);
    check("meas_low_in_range", int'(meas_lo >= 49 && meas_lo <= 51), 1);
    check("measure_done", int'(hi_seen && lo_seen), 1);

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/digital_signal_generate.md
Name: digital_signal_generate

Overview:
- Programmable pulse/PWM generator. It drives a pin with a waveform of programmed high time and low time, counted in clk cycles.
- It is the transmit-side counterpart of the digital signal measurement block. Its output can be looped back into that block for self-test.
- It sits in the logic subsystem, controlled by a command/register layer through a level-sensitive start/done handshake.

Parameters:
- CNT_W, 16, width of the high-time, low-time and pulse-count fields and their counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- gen_start  in  1  level request. Held high to run; dropping it stops the generator.
- high_time  in  CNT_W  cycles gen_pin is held high per period.
- low_time  in  CNT_W  cycles gen_pin is held low per period.
- pulse_count  in  CNT_W  number of periods to emit. 0 means continuous.
- gen_pin  out  1  generated waveform, registered.
- gen_busy  out  1  high while in state HIGH or LOW.
- gen_done  out  1  high in DONE after a finite burst completes.
- period_cnt  out  CNT_W  periods completed in the current burst.

Behaviour:
- Reset (async, rst=1): state=IDLE; gen_pin=0, gen_busy=0, gen_done=0, period_cnt=0; all internal counters and shadow registers=0.
- States: IDLE, HIGH, LOW, DONE.
- Shadow registers:
  - hi_s and lo_s latch high_time and low_time on IDLE->HIGH and on every LOW->HIGH transition. Mid-run changes to the inputs therefore take effect only at the next period boundary (glitch-free).
  - cnt_s latches pulse_count only on IDLE->HIGH.
- Clamping: a latched value of 0 for hi_s or lo_s is treated as 1. A pin level never lasts 0 cycles.
- IDLE:
  - gen_pin=0.
  - If gen_start is sampled 1 at edge N: at edge N+1 state=HIGH, gen_pin=1, phase counter=1, period_cnt=0, gen_done=0.
- HIGH:
  - gen_pin stays 1 for exactly hi_s cycles.
  - When phase counter == hi_s: next edge goes to LOW, gen_pin=0, phase counter=1.
- LOW:
  - gen_pin stays 0 for exactly lo_s cycles.
  - When phase counter == lo_s: period_cnt increments at the next edge, then:
    - gen_start=0 -> IDLE (abort; gen_done stays 0).
    - cnt_s!=0 and period_cnt+1 == cnt_s -> DONE.
    - otherwise -> HIGH: relatch hi_s/lo_s, gen_pin=1, phase counter=1.
- gen_start deassert during HIGH/LOW: the current period always completes. The check is made only at the end of LOW, so no truncated pulse is ever emitted.
- DONE:
  - gen_done=1, gen_pin=0.
  - Stays in DONE while gen_start=1. When gen_start=0, goes to IDLE at the next edge and clears gen_done.
  - A new burst requires gen_start to go low and then high again.
- Continuous mode (cnt_s=0): runs indefinitely. period_cnt wraps from 2^CNT_W-1 to 0 without side effects.
- Period length is hi_s+lo_s cycles. Duty cycle is exact, with no dead cycles between periods.
- Counters: phase counter is CNT_W bits and never exceeds max(hi_s,lo_s). Comparison uses equality; no arithmetic overflow is possible.
- Reset asserted mid-burst: immediately returns gen_pin=0 and all outputs to reset values, asynchronously.
- gen_busy is combinational from state (HIGH or LOW); gen_pin is a flop output.

Decomposition:
- Shared package digital_signal_pkg holds:
  - the state enum (IDLE, HIGH, LOW, DONE);
  - localparam DEFAULT_CNT_W=16, shared with the measurement block.
- Single module; no sub-module is warranted.

Test Plan:
- Basic burst: hi=5, lo=3, count=2, gen_start=1 at edge 0.
  - gen_pin high edges 1-5, low 6-8, high 9-13, low 14-16.
  - gen_done=1 from edge 17; period_cnt=2.
- Clamp: hi=0, lo=0, count=3 -> pin toggles every cycle for 6 cycles (1,0,1,0,1,0), then DONE.
- Continuous mode with abort: hi=4, lo=4, count=0.
  - Drop gen_start mid-HIGH of the third period.
  - That period completes (8 cycles), then IDLE with gen_done=0 and period_cnt=3.
- Mid-run update: hi=2, lo=2, count=4; change high_time to 6 during the first HIGH.
  - Period 1 keeps hi=2; periods 2-4 are 6 high/2 low.
  - pulse_count changed mid-run is ignored.
- Async reset: assert rst during LOW of burst hi=10, lo=10.
  - gen_pin, gen_busy, gen_done, period_cnt are 0 before the next clk edge.
  - Releasing rst with gen_start=1 restarts a fresh burst.
- Loopback into the measurement block: hi=100, lo=50, count=0 -> measured high_time and low_time each within 1 count of 100 and 50; measure_done asserts.
